// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline control types
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_NOP    = 2'd1,
    PIPE_STALL  = 2'd2,
    PIPE_FLUSH  = 2'd3
  } pipe_state_t;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/pipeline_stage_reg_if.sv
// rtl/pipeline_stage_reg_if.sv - upstream/downstream ready-valid handshake bundle
interface pipeline_stage_reg_if #(
  parameter int DATA_W = 128
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_slice.sv
// rtl/pipe_slice.sv - one valid+payload register with load/hold/clear
module pipe_slice #(
  parameter int                DATA_W  = 128,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_valid <= 1'b0;
      r_data  <= NOP_VAL;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_data  <= i_valid ? i_data : NOP_VAL;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/pipeline_stage_reg.sv
// rtl/pipeline_stage_reg.sv - elastic DEPTH-slice stage register with hazard commands
// PIPE_SKID_EN adds a one-entry skid ahead of slice 0 and decouples in_ready from out_ready.
module pipeline_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int                DATA_W  = 128,
  parameter int                DEPTH   = 1,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  pipe_state_t                cmd,
  pipeline_stage_reg_if.slave        bus,
  output logic [$clog2(DEPTH+2)-1:0] occupancy,
  output logic [15:0]                stall_cnt
);
  localparam int OCC_W = $clog2(DEPTH+2);

  logic              w_enable, w_nop, w_flush, w_hold, w_run;
  logic              w_in_ready, w_fire;
  logic              w_head_v;
  logic [DATA_W-1:0] w_head_d;
  logic [DEPTH-1:0]  w_v, w_adv, w_load, w_src_v, w_nxt_v;
  logic [DATA_W-1:0] w_d     [DEPTH];
  logic [DATA_W-1:0] w_src_d [DEPTH];
  logic [OCC_W-1:0]  w_occ_nxt, r_occ;
  logic [15:0]       r_stall_cnt;

  always_comb begin
    w_enable = 1'b0;
    w_nop    = 1'b0;
    w_flush  = 1'b0;
    w_hold   = 1'b0;
    case (cmd)
      PIPE_ENABLE: w_enable = 1'b1;
      PIPE_NOP:    w_nop    = 1'b1;
      PIPE_FLUSH:  w_flush  = 1'b1;
      default:     w_hold   = 1'b1;
    endcase
  end

  assign w_run = w_enable || w_nop;

`ifdef PIPE_SKID_EN
  logic              r_skid_v, w_skid_nxt_v;
  logic [DATA_W-1:0] r_skid_d, w_skid_nxt_d;

  assign w_in_ready = w_enable && !r_skid_v;
  assign w_fire     = bus.in_valid && w_in_ready;
  // A held skid entry always goes ahead of fresh input to keep order.
  assign w_head_v   = r_skid_v || w_fire;
  assign w_head_d   = r_skid_v ? r_skid_d : bus.in_data;

  always_comb begin
    w_skid_nxt_v = r_skid_v;
    w_skid_nxt_d = r_skid_d;
    if (w_flush) begin
      w_skid_nxt_v = 1'b0;
      w_skid_nxt_d = NOP_VAL;
    end else if (w_run) begin
      if (r_skid_v && w_adv[0]) begin
        w_skid_nxt_v = 1'b0;
        w_skid_nxt_d = NOP_VAL;
      end else if (!r_skid_v && w_fire && !w_adv[0]) begin
        w_skid_nxt_v = 1'b1;
        w_skid_nxt_d = bus.in_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_skid_v <= 1'b0;
      r_skid_d <= NOP_VAL;
    end else begin
      r_skid_v <= w_skid_nxt_v;
      r_skid_d <= w_skid_nxt_d;
    end
  end
`else
  assign w_in_ready = w_enable && w_adv[0];
  assign w_fire     = bus.in_valid && w_in_ready;
  assign w_head_v   = w_fire;
  assign w_head_d   = bus.in_data;
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_slice
    if (g == 0) begin : g_head
      assign w_src_v[g] = w_head_v;
      assign w_src_d[g] = w_head_d;
    end else begin : g_chain
      assign w_src_v[g] = w_v[g-1];
      assign w_src_d[g] = w_d[g-1];
    end

    // A slice can move when it, or any slice downstream of it, has room.
    assign w_adv[g]   = bus.out_ready || !(&w_v[DEPTH-1:g]);
    assign w_load[g]  = w_run && w_adv[g];
    assign w_nxt_v[g] = !w_flush && (w_load[g] ? w_src_v[g] : w_v[g]);

    pipe_slice #(
      .DATA_W  (DATA_W),
      .NOP_VAL (NOP_VAL)
    ) u_slice (
      .clk     (CLK),
      .rst     (RST),
      .i_load  (w_load[g]),
      .i_clear (w_flush),
      .i_valid (w_src_v[g]),
      .i_data  (w_src_d[g]),
      .o_valid (w_v[g]),
      .o_data  (w_d[g])
    );
  end

  always_comb begin
    w_occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_nxt_v[i]);
    end
`ifdef PIPE_SKID_EN
    w_occ_nxt = w_occ_nxt + OCC_W'(w_skid_nxt_v);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_occ       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_occ <= w_occ_nxt;
      if (w_hold && (r_stall_cnt != STALL_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_v[DEPTH-1] && w_run;
  assign bus.out_data  = w_d[DEPTH-1];
  assign occupancy     = r_occ;
  assign stall_cnt     = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_stage_reg.sv
// tb/tb_pipeline_stage_reg.sv - directed self-checking bench for pipeline_stage_reg
module tb_pipeline_stage_reg;
  import cpu_types_pkg::*;

  localparam int             DW    = 32;
  localparam int             DEPTH = 3;
  localparam logic [DW-1:0]  NOP   = 32'h0BAD_0000;
`ifdef PIPE_SKID_EN
  localparam int             CAP   = DEPTH + 1;
`else
  localparam int             CAP   = DEPTH;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  pipe_state_t cmd = PIPE_ENABLE;
  logic [2:0]  occupancy;
  logic [15:0] stall_cnt;

  pipeline_stage_reg_if #(.DATA_W(DW)) bus ();

  pipeline_stage_reg #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .NOP_VAL (NOP)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cmd       (cmd),
    .bus       (bus),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a row of DEPTH seats; each cycle the head leaves if accepted downstream,
  // then every payload slides forward into an empty seat, then the entry seat fills.
  bit            m_v  [DEPTH];
  logic [DW-1:0] m_d  [DEPTH];
  bit            m_sk_v;
  logic [DW-1:0] m_sk_d;
  int            m_stall;
  int            m_cyc = 0;
  int            m_cnt;
  bit            m_live = 0;
  bit            m_ir, m_run, m_acc;
  logic [DW-1:0] push_q[$];
  int            push_t[$];
  logic [DW-1:0] pop_q[$];
  int            pop_t[$];

  always @(negedge CLK) begin
    m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) m_cnt += int'(m_v[i]);
`ifdef PIPE_SKID_EN
    m_ir = (cmd == PIPE_ENABLE) && !m_sk_v;
`else
    m_ir = (cmd == PIPE_ENABLE) && ((m_cnt < DEPTH) || bus.out_ready);
`endif
    m_run = (cmd == PIPE_ENABLE) || (cmd == PIPE_NOP);
    if (m_live) begin
      check("out_valid", 32'(bus.out_valid), 32'(m_v[DEPTH-1] && m_run));
      check("out_data",  bus.out_data,       m_d[DEPTH-1]);
      check("in_ready",  32'(bus.in_ready),  32'(m_ir));
      check("occupancy", 32'(occupancy),     32'(m_cnt + int'(m_sk_v)));
      check("stall_cnt", 32'(stall_cnt),     32'(m_stall));
    end
    m_cyc++;
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin m_v[i] = 0; m_d[i] = NOP; end
      m_sk_v = 0; m_sk_d = NOP; m_stall = 0; m_live = 1;
    end else if (cmd == PIPE_FLUSH) begin
      for (int i = 0; i < DEPTH; i++) begin m_v[i] = 0; m_d[i] = NOP; end
      m_sk_v = 0; m_sk_d = NOP;
    end else if (m_run) begin
      m_acc = m_ir && bus.in_valid;
      if (m_v[DEPTH-1] && bus.out_ready) begin
        pop_q.push_back(m_d[DEPTH-1]);
        pop_t.push_back(m_cyc);
        m_v[DEPTH-1] = 0; m_d[DEPTH-1] = NOP;
      end
      for (int i = DEPTH-1; i > 0; i--) begin
        if (!m_v[i]) begin
          m_v[i] = m_v[i-1]; m_d[i] = m_d[i-1];
          m_v[i-1] = 0; m_d[i-1] = NOP;
        end
      end
      if (m_sk_v && !m_v[0]) begin
        m_v[0] = 1; m_d[0] = m_sk_d; m_sk_v = 0; m_sk_d = NOP;
      end
      if (m_acc) begin
        push_q.push_back(bus.in_data);
        push_t.push_back(m_cyc);
        if (!m_v[0]) begin m_v[0] = 1; m_d[0] = bus.in_data; end
        else begin m_sk_v = 1; m_sk_d = bus.in_data; end
      end
    end else if (m_stall < 65535) begin
      m_stall++;
    end
  end

  task automatic drive(input pipe_state_t c, input logic iv, input logic [DW-1:0] d, input logic ordy);
    @(posedge CLK);
    #1;
    cmd = c; bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy;
  endtask

  task automatic clear_logs();
    push_q.delete(); push_t.delete(); pop_q.delete(); pop_t.delete();
  endtask

  int pk;

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1; RST = 1'b0;
    #1;
    check("hand_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("hand_rst_out_data",  bus.out_data,       NOP);
    check("hand_rst_occupancy", 32'(occupancy),     32'd0);
    check("hand_rst_stall_cnt", 32'(stall_cnt),     32'd0);

    // Back-to-back A,B,C with no backpressure.
    clear_logs(); pk = 0;
    drive(PIPE_ENABLE, 1, 32'hA, 1);
    drive(PIPE_ENABLE, 1, 32'hB, 1);
    drive(PIPE_ENABLE, 1, 32'hC, 1);
    for (int i = 0; i < 6; i++) begin
      drive(PIPE_ENABLE, 0, '0, 1);
      #1; if (int'(occupancy) > pk) pk = int'(occupancy);
    end
    check("hand_abc_count", 32'(pop_q.size()), 32'd3);
    check("hand_abc_0", pop_q[0], 32'hA);
    check("hand_abc_1", pop_q[1], 32'hB);
    check("hand_abc_2", pop_q[2], 32'hC);
    check("hand_abc_latency", 32'(pop_t[0] - push_t[0]), 32'd3);
    check("hand_abc_thru", 32'(pop_t[2] - pop_t[0]), 32'd2);
    check("hand_abc_peak_occ", 32'(pk), 32'd3);

    // Fill under backpressure, then simultaneous push and pop.
    clear_logs();
    drive(PIPE_ENABLE, 1, 32'hD, 0);
    drive(PIPE_ENABLE, 1, 32'hE, 0);
    drive(PIPE_ENABLE, 1, 32'hF, 0);
    for (int i = 0; i < 3; i++) begin
      drive(PIPE_ENABLE, 1, 32'h10, 0);
      #1;
      check("hand_full_in_ready", 32'(bus.in_ready), 32'd0);
      check("hand_full_out_data", bus.out_data, 32'hD);
    end
    drive(PIPE_ENABLE, 1, 32'h10, 1);
    #1; check("hand_full_swap_ready", 32'(bus.in_ready), 32'd1);
    drive(PIPE_ENABLE, 0, '0, 1);
    #1; check("hand_full_swap_occ", 32'(occupancy), 32'd3);
    repeat (5) drive(PIPE_ENABLE, 0, '0, 1);
    check("hand_full_count", 32'(pop_q.size()), 32'd4);
    check("hand_full_first", pop_q[0], 32'hD);
    check("hand_full_last",  pop_q[3], 32'h10);

    // Single NOP cycle with a payload waiting upstream.
    clear_logs();
    drive(PIPE_ENABLE, 1, 32'h58, 1);
    drive(PIPE_NOP,    1, 32'h59, 1);
    #1; check("hand_nop_in_ready", 32'(bus.in_ready), 32'd0);
    drive(PIPE_ENABLE, 1, 32'h59, 1);
    repeat (6) drive(PIPE_ENABLE, 0, '0, 1);
    check("hand_nop_count", 32'(pop_q.size()), 32'd2);
    check("hand_nop_x", pop_q[0], 32'h58);
    check("hand_nop_y", pop_q[1], 32'h59);
    check("hand_nop_bubble", 32'(pop_t[1] - pop_t[0]), 32'd2);

    // Five stall cycles mid-stream.
    clear_logs();
    drive(PIPE_ENABLE, 1, 32'h50, 1);
    drive(PIPE_ENABLE, 1, 32'h51, 1);
    drive(PIPE_ENABLE, 1, 32'h52, 1);
    for (int i = 0; i < 5; i++) begin
      drive(PIPE_STALL, 1, 32'h53, 1);
      #1;
      check("hand_stall_out_valid", 32'(bus.out_valid), 32'd0);
      check("hand_stall_out_data",  bus.out_data, 32'h50);
    end
    drive(PIPE_ENABLE, 1, 32'h53, 1);
    repeat (6) drive(PIPE_ENABLE, 0, '0, 1);
    check("hand_stall_cnt", 32'(stall_cnt), 32'd5);
    check("hand_stall_count", 32'(pop_q.size()), 32'd4);
    check("hand_stall_first", pop_q[0], 32'h50);
    check("hand_stall_last",  pop_q[3], 32'h53);

    // Flush with payloads in flight.
    clear_logs();
    drive(PIPE_ENABLE, 1, 32'h70, 1);
    drive(PIPE_ENABLE, 1, 32'h71, 1);
    drive(PIPE_FLUSH,  1, 32'h72, 1);
    #1; check("hand_flush_in_ready", 32'(bus.in_ready), 32'd0);
    drive(PIPE_ENABLE, 0, '0, 1);
    #1;
    check("hand_flush_occ",       32'(occupancy), 32'd0);
    check("hand_flush_stall_cnt", 32'(stall_cnt), 32'd5);
    check("hand_flush_out_data",  bus.out_data, NOP);
    repeat (4) drive(PIPE_ENABLE, 0, '0, 1);
    check("hand_flush_no_pops", 32'(pop_q.size()), 32'd0);

    // Capacity under continuous backpressure, then drain in order.
    clear_logs();
    for (int i = 0; i < 6; i++) drive(PIPE_ENABLE, 1, 32'(32'h600 + i), 0);
    #1;
    check("hand_cap_accepted", 32'(push_q.size()), 32'(CAP));
    check("hand_cap_occ",      32'(occupancy),     32'(CAP));
    check("hand_cap_in_ready", 32'(bus.in_ready),  32'd0);
    repeat (8) drive(PIPE_ENABLE, 0, '0, 1);
    check("hand_cap_count", 32'(pop_q.size()), 32'(CAP));
    check("hand_cap_first", pop_q[0], 32'h600);
    check("hand_cap_last",  pop_q[CAP-1], 32'(32'h600 + CAP - 1));

    @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
